exe_status_ctrl: RTL and testbench

EXE_STATUS_CTRL -- requirements
Module: exe_status_ctrl

---
 rtl/exe_status_ctrl.sv | 155 +++++++++++++++
 tb/tb_exe_status_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_status_ctrl.sv
// EXE stage register with condition evaluation, status-register update and
// branch resolution for a conditional-execution pipeline.
module exe_status_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [3:0]        id_cond,
    input  logic              id_s,
    input  logic              id_wb_en,
    input  logic              id_mem_r,
    input  logic              id_mem_w,
    input  logic              id_branch,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [23:0]       id_imm24,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        alu_status,
    output logic [3:0]        EXE_CMD,
    output logic [DATA_W-1:0] Val1,
    output logic [DATA_W-1:0] Val2,
    output logic              carry,
    output logic [REG_W-1:0]  exe_dest,
    output logic              exe_wb_en,
    output logic              exe_mem_r,
    output logic              exe_mem_w,
    output logic [3:0]        sr,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target
);

    logic              vld_p0;
    logic [3:0]        cmd_p0;
    logic [DATA_W-1:0] val1_p0;
    logic [DATA_W-1:0] val2_p0;
    logic [REG_W-1:0]  dest_p0;
    logic [3:0]        cond_p0;
    logic              s_p0;
    logic              wb_en_p0;
    logic              mem_r_p0;
    logic              mem_w_p0;
    logic              branch_p0;
    logic [DATA_W-1:0] pc_p0;
    logic [23:0]       imm_p0;
    logic              sr_done_p0;

    logic              cond_pass;
    logic              exec;
    logic              sr_upd;
    logic              bubble;
    logic signed [DATA_W-1:0] br_off;

    // flags are {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'd0:    cond_check = z;
            4'd1:    cond_check = ~z;
            4'd2:    cond_check = cf;
            4'd3:    cond_check = ~cf;
            4'd4:    cond_check = n;
            4'd5:    cond_check = ~n;
            4'd6:    cond_check = v;
            4'd7:    cond_check = ~v;
            4'd8:    cond_check = cf & ~z;
            4'd9:    cond_check = ~cf | z;
            4'd10:   cond_check = (n == v);
            4'd11:   cond_check = (n != v);
            4'd12:   cond_check = ~z & (n == v);
            4'd13:   cond_check = z | (n != v);
            4'd14:   cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    assign cond_pass = cond_check(cond_p0, sr);
    assign exec      = vld_p0 & cond_pass;
    // sr_done keeps a stalled S instruction from re-sampling alu_status
    assign sr_upd    = exec & s_p0 & ~branch_p0 & ~sr_done_p0;
    assign bubble    = flush | branch_taken;

    assign br_off        = DATA_W'($signed(imm_p0)) <<< 2;
    assign branch_target = pc_p0 + $unsigned(br_off);
    assign branch_taken  = exec & branch_p0;

    assign EXE_CMD   = cmd_p0;
    assign Val1      = val1_p0;
    assign Val2      = val2_p0;
    assign exe_dest  = dest_p0;
    assign exe_wb_en = wb_en_p0 & exec;
    assign exe_mem_r = mem_r_p0 & exec;
    assign exe_mem_w = mem_w_p0 & exec;
    assign carry     = sr[1];

    // ID -> EXE stage boundary; sr updates independently of stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0     <= 1'b0;
            cmd_p0     <= '0;
            val1_p0    <= '0;
            val2_p0    <= '0;
            dest_p0    <= '0;
            cond_p0    <= '0;
            s_p0       <= 1'b0;
            wb_en_p0   <= 1'b0;
            mem_r_p0   <= 1'b0;
            mem_w_p0   <= 1'b0;
            branch_p0  <= 1'b0;
            pc_p0      <= '0;
            imm_p0     <= '0;
            sr_done_p0 <= 1'b0;
            sr         <= 4'b0000;
        end else begin
            if (sr_upd)
                sr <= alu_status;
            if (bubble) begin
                vld_p0     <= 1'b0;
                s_p0       <= 1'b0;
                wb_en_p0   <= 1'b0;
                mem_r_p0   <= 1'b0;
                mem_w_p0   <= 1'b0;
                branch_p0  <= 1'b0;
                sr_done_p0 <= 1'b0;
            end else if (stall) begin
                sr_done_p0 <= sr_done_p0 | sr_upd;
            end else begin
                vld_p0     <= id_valid;
                cmd_p0     <= id_exe_cmd;
                val1_p0    <= id_val1;
                val2_p0    <= id_val2;
                dest_p0    <= id_dest;
                cond_p0    <= id_cond;
                s_p0       <= id_s;
                wb_en_p0   <= id_wb_en;
                mem_r_p0   <= id_mem_r;
                mem_w_p0   <= id_mem_w;
                branch_p0  <= id_branch;
                pc_p0      <= id_pc;
                imm_p0     <= id_imm24;
                sr_done_p0 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_status_ctrl.sv
// Bench for exe_status_ctrl: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model.
module tb_exe_status_ctrl;

    typedef struct packed {
        logic        v;
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  dest;
        logic [3:0]  cond;
        logic        s;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        br;
        logic [31:0] pc;
        logic [23:0] imm;
        logic        done;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [3:0]  alu;
    ins_t        inp;

    logic [3:0]  EXE_CMD;
    logic [31:0] Val1, Val2, branch_target;
    logic        carry, exe_wb_en, exe_mem_r, exe_mem_w, branch_taken;
    logic [3:0]  exe_dest, sr;

    ins_t        m;
    logic [3:0]  msr;

    int checks = 0;
    int failures = 0;

    exe_status_ctrl #(.DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(inp.v), .id_exe_cmd(inp.cmd), .id_val1(inp.v1), .id_val2(inp.v2),
        .id_dest(inp.dest), .id_cond(inp.cond), .id_s(inp.s), .id_wb_en(inp.wb),
        .id_mem_r(inp.mr), .id_mem_w(inp.mw), .id_branch(inp.br),
        .id_pc(inp.pc), .id_imm24(inp.imm),
        .stall(stall), .flush(flush), .alu_status(alu),
        .EXE_CMD(EXE_CMD), .Val1(Val1), .Val2(Val2), .carry(carry),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r(exe_mem_r),
        .exe_mem_w(exe_mem_w), .sr(sr), .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit r;
        case (c)
            0: r = z;               1: r = !z;
            2: r = cy;              3: r = !cy;
            4: r = n;               5: r = !n;
            6: r = v;               7: r = !v;
            8: r = cy && !z;        9: r = !cy || z;
            10: r = n == v;         11: r = n != v;
            12: r = !z && n == v;   13: r = z || n != v;
            14: r = 1;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] target_of(input ins_t i);
        int off;
        off = int'($signed(i.imm)) * 4;
        return i.pc + off;
    endfunction

    task automatic model_reset();
        m   = '0;
        msr = 4'b0000;
    endtask

    task automatic compare_outputs();
        logic ex;
        ex = m.v && cond_ok(m.cond, msr);
        chk("sr", sr, msr);
        chk("carry", carry, msr[1]);
        chk("branch_taken", branch_taken, ex && m.br);
        chk("exe_wb_en", exe_wb_en, ex && m.wb);
        chk("exe_mem_r", exe_mem_r, ex && m.mr);
        chk("exe_mem_w", exe_mem_w, ex && m.mw);
        if (m.v) begin
            chk("exe_cmd", EXE_CMD, m.cmd);
            chk("val1", Val1, m.v1);
            chk("val2", Val2, m.v2);
            chk("exe_dest", exe_dest, m.dest);
            if (m.br) chk("branch_target", branch_target, target_of(m));
        end
    endtask

    task automatic model_edge();
        logic ex, bt, upd;
        ex  = m.v && cond_ok(m.cond, msr);
        bt  = ex && m.br;
        upd = ex && m.s && !m.br && !m.done;
        if (upd) msr = alu;
        if (flush || bt) begin
            m.v = 0; m.s = 0; m.wb = 0; m.mr = 0; m.mw = 0; m.br = 0; m.done = 0;
        end else if (stall) begin
            m.done = m.done | upd;
        end else begin
            m      = inp;
            m.done = 0;
        end
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic step();
        #1 compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [3:0] cmd, input logic [3:0] cond, input logic s,
                           input logic wb, input logic br, input logic [31:0] pc,
                           input logic [23:0] imm);
        inp      = '0;
        inp.v    = 1;
        inp.cmd  = cmd;
        inp.v1   = 32'd5;
        inp.v2   = 32'd7;
        inp.dest = 4'd3;
        inp.cond = cond;
        inp.s    = s;
        inp.wb   = wb;
        inp.br   = br;
        inp.pc   = pc;
        inp.imm  = imm;
    endtask

    task automatic rnd_inputs();
        inp.v    = ($urandom % 8) != 0;
        inp.cmd  = 4'($urandom);
        inp.v1   = $urandom;
        inp.v2   = $urandom;
        inp.dest = 4'($urandom);
        inp.cond = ($urandom % 2) ? 4'd14 : 4'($urandom);
        inp.s    = 1'($urandom);
        inp.wb   = 1'($urandom);
        inp.mr   = 1'($urandom);
        inp.mw   = 1'($urandom);
        inp.br   = ($urandom % 5) == 0;
        inp.pc   = $urandom & 32'hFFFF_FFFC;
        inp.imm  = 24'($urandom);
        inp.done = 0;
        stall    = ($urandom % 4) == 0;
        flush    = ($urandom % 10) == 0;
        alu      = 4'($urandom);
    endtask

    task automatic async_reset_check();
        rst = 0;
        #1;
        chk("rst_sr", sr, 4'b0000);
        chk("rst_carry", carry, 1'b0);
        chk("rst_branch_taken", branch_taken, 1'b0);
        chk("rst_wb_en", exe_wb_en, 1'b0);
        chk("rst_mem_r", exe_mem_r, 1'b0);
        chk("rst_mem_w", exe_mem_w, 1'b0);
        chk("rst_cmd", EXE_CMD, 4'd0);
        chk("rst_val1", Val1, 32'd0);
        chk("rst_val2", Val2, 32'd0);
        chk("rst_dest", exe_dest, 4'd0);
        model_reset();
        #1 rst = 1;
    endtask

    initial begin
        rst = 0; stall = 0; flush = 0; alu = 0; inp = '0;
        model_reset();
        #2 async_reset_check();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;

        // ADD, s=1, AL
        set_ins(4'd2, 4'd14, 1, 1, 0, 32'h0, 24'h0);
        step();
        chk("add_cmd", EXE_CMD, 4'd2);
        chk("add_val1", Val1, 32'd5);
        chk("add_val2", Val2, 32'd7);
        chk("add_wb_en", exe_wb_en, 1'b1);
        alu = 4'b0000;
        set_ins(4'd1, 4'd14, 1, 0, 0, 32'h0, 24'h0);
        step();
        chk("add_sr", sr, 4'b0000);

        // set Z, then BEQ back-to-back
        alu = 4'b0100;
        set_ins(4'd0, 4'd0, 0, 0, 1, 32'h100, 24'hFFFFFE);
        step();
        chk("beq_sr", sr, 4'b0100);
        chk("beq_taken", branch_taken, 1'b1);
        chk("beq_target", branch_target, 32'h0F8);
        set_ins(4'd2, 4'd14, 0, 1, 0, 32'h0, 24'h0);
        step();
        chk("beq_bubble_wb", exe_wb_en, 1'b0);

        // clear flags, then MOV EQ must not execute
        set_ins(4'd1, 4'd14, 1, 0, 0, 32'h0, 24'h0);
        step();
        alu = 4'b0000;
        set_ins(4'd1, 4'd0, 1, 1, 0, 32'h0, 24'h0);
        step();
        alu = 4'b1111;
        step();
        chk("mov_eq_wb", exe_wb_en, 1'b0);
        step();
        chk("mov_eq_sr", sr, 4'b0000);

        // S instruction held by stall
        set_ins(4'd2, 4'd14, 1, 1, 0, 32'h0, 24'h0);
        step();
        alu = 4'b1010; stall = 1;
        step();
        chk("stall_sr_first", sr, 4'b1010);
        alu = 4'b0101;
        step();
        step();
        chk("stall_sr_held", sr, 4'b1010);

        // stall + flush gives a bubble
        flush = 1;
        step();
        chk("stall_flush_wb", exe_wb_en, 1'b0);
        stall = 0; flush = 0;

        // reset mid-branch with sr=1111
        set_ins(4'd2, 4'd14, 1, 0, 0, 32'h0, 24'h0);
        step();
        alu = 4'b1111;
        set_ins(4'd0, 4'd14, 0, 0, 1, 32'h200, 24'h000010);
        step();
        chk("pre_rst_sr", sr, 4'b1111);
        chk("pre_rst_taken", branch_taken, 1'b1);
        async_reset_check();

        for (int i = 0; i < 600; i++) begin
            rnd_inputs();
            if (($urandom % 64) == 0) async_reset_check();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
